sync_fifo_ctrl: RTL and testbench

//  Single-clock parametrised FIFO: storage array plus pointer/flag control in one block.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_mem_bank.sv | 36 +++
 rtl/sync_fifo_ctrl.sv | 145 ++++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: pointer sizing, log2 and flag-threshold checks.
package fifo_pkg;

  localparam int unsigned PtrExtraBits = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if (((value - 1) >> i) != 0) result = i + 1;
    end
    return result;
  endfunction

  // Extra MSB separates a full FIFO from an empty one when the low bits match.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + PtrExtraBits;
  endfunction

  function automatic logic at_or_above(input int unsigned count, input int unsigned thresh);
    return logic'(count >= thresh);
  endfunction

  function automatic logic at_or_below(input int unsigned count, input int unsigned thresh);
    return logic'(count <= thresh);
  endfunction

endpackage

// File: rtl/fifo_mem_bank.sv
// FIFO storage: one synchronous write port, one asynchronous read port, asynchronous clear.
module fifo_mem_bank
  import fifo_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 8,
  localparam int unsigned AddrWidth = (Depth > 1) ? clog2(Depth) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] mem_d [Depth];

  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/empty flags and synchronous flush.
// Optional sticky OVERFLOW/UNDERFLOW with ERR_CLR when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_THRESH  = 6,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  FLUSH,
  input  logic                  W_INC,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  R_INC,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                  ERR_CLR,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
`endif
);

  localparam int unsigned PtrW      = ptr_width(ADDR_WIDTH);
  localparam int unsigned FifoDepth = 2 ** ADDR_WIDTH;

  typedef logic [PtrW-1:0] ptr_t;

  localparam ptr_t DepthP = ptr_t'(FifoDepth);

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic afull_q, afull_d;
  logic aempty_q, aempty_d;
  logic wr_en, rd_en;

  // Acceptance looks only at registered flags; flush suppresses both requests.
  assign wr_en = W_INC && !full_q && !FLUSH;
  assign rd_en = R_INC && !empty_q && !FLUSH;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (FLUSH) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + ptr_t'(1);
      if (rd_en) rptr_d = rptr_q + ptr_t'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + ptr_t'(1);
        2'b01:   count_d = count_q - ptr_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Flags are registered from the next-state count so they move with the pointers.
  always_comb begin
    full_d   = (count_d == DepthP);
    empty_d  = (count_d == '0);
    afull_d  = at_or_above(int'(count_d), AF_THRESH);
    aempty_d = at_or_below(int'(count_d), AE_THRESH);
  end

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= at_or_above(0, AF_THRESH);
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  fifo_mem_bank #(
    .DataWidth(DATA_WIDTH),
    .Depth    (FifoDepth)
  ) u_mem (
    .clk_i  (W_CLK),
    .rst_i  (W_RST),
    .we_i   (wr_en),
    .waddr_i(wptr_q[ADDR_WIDTH-1:0]),
    .wdata_i(WR_DATA),
    .raddr_i(rptr_q[ADDR_WIDTH-1:0]),
    .rdata_o(RD_DATA)
  );

  assign FULL         = full_q;
  assign EMPTY        = empty_q;
  assign ALMOST_FULL  = afull_q;
  assign ALMOST_EMPTY = aempty_q;
  assign COUNT        = count_q;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Clear beats a coincident set.
  always_comb begin
    overflow_d  = overflow_q | (W_INC & full_q);
    underflow_d = underflow_q | (R_INC & empty_q);
    if (FLUSH || ERR_CLR) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign OVERFLOW  = overflow_q;
  assign UNDERFLOW = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl (8x8, AF=6, AE=2) with a queue reference model.
module tb_sync_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       w_inc;
  logic [7:0] wr_data;
  logic       r_inc;
  logic [7:0] rd_data;
  logic       full, empty, afull, aempty;
  logic [3:0] count;
`ifdef SYNC_FIFO_ERR_EN
  logic       err_clr;
  logic       overflow, underflow;
`endif

  int n_checks;
  int n_fail;
  logic [7:0] model_q[$];

  sync_fifo_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3),
    .AF_THRESH (6),
    .AE_THRESH (2)
  ) dut (
    .W_CLK       (clk),
    .W_RST       (rst),
    .FLUSH       (flush),
    .W_INC       (w_inc),
    .WR_DATA     (wr_data),
    .R_INC       (r_inc),
    .RD_DATA     (rd_data),
    .FULL        (full),
    .EMPTY       (empty),
    .ALMOST_FULL (afull),
    .ALMOST_EMPTY(aempty),
    .COUNT       (count)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .ERR_CLR     (err_clr),
    .OVERFLOW    (overflow),
    .UNDERFLOW   (underflow)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests, then update the reference model from pre-edge occupancy.
  task automatic cyc(input logic w, input logic [7:0] wd, input logic r, input logic f);
    logic rd_ok, wr_ok;
    w_inc   = w;
    wr_data = wd;
    r_inc   = r;
    flush   = f;
    rd_ok   = r && (model_q.size() > 0);
    wr_ok   = w && (model_q.size() < 8);
    @(posedge clk);
    #1;
    if (f) begin
      model_q.delete();
    end else begin
      if (rd_ok) void'(model_q.pop_front());
      if (wr_ok) model_q.push_back(wd);
    end
    w_inc = 1'b0;
    r_inc = 1'b0;
    flush = 1'b0;
  endtask

  task automatic check_state(input string tag);
    int n;
    n = model_q.size();
    check_eq({tag, ".count"}, 32'(count), 32'(n));
    check_eq({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check_eq({tag, ".full"}, 32'(full), 32'(n == 8));
    check_eq({tag, ".afull"}, 32'(afull), 32'(n >= 6));
    check_eq({tag, ".aempty"}, 32'(aempty), 32'(n <= 2));
    if (n > 0) check_eq({tag, ".rd_data"}, 32'(rd_data), 32'(model_q[0]));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    w_inc    = 1'b0;
    r_inc    = 1'b0;
    wr_data  = 8'h00;
`ifdef SYNC_FIFO_ERR_EN
    err_clr  = 1'b0;
`endif
    #12;
    check_eq("rst.count", 32'(count), 32'd0);
    check_eq("rst.empty", 32'(empty), 32'd1);
    check_eq("rst.aempty", 32'(aempty), 32'd1);
    check_eq("rst.full", 32'(full), 32'd0);
    check_eq("rst.afull", 32'(afull), 32'd0);
    check_eq("rst.rd_data", 32'(rd_data), 32'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle.count", 32'(count), 32'd0);
    check_eq("idle.empty", 32'(empty), 32'd1);

    // Fill 0x01..0x08 and try one overflow write.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      check_state("fill");
      check_eq("fill.count_abs", 32'(count), 32'(i));
    end
    check_eq("fill.head", 32'(rd_data), 32'h01);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    check_state("ovf");
    check_eq("ovf.count", 32'(count), 32'd8);
`ifdef SYNC_FIFO_ERR_EN
    check_eq("ovf.flag", 32'(overflow), 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check_eq("ovf.clr", 32'(overflow), 32'd0);
`endif

    // Drain in order, then one underflow read.
    for (int i = 1; i <= 8; i++) begin
      check_eq("drain.rd_data", 32'(rd_data), 32'(i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check_state("drain");
    end
    check_eq("drain.empty", 32'(empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_state("udf");
`ifdef SYNC_FIFO_ERR_EN
    check_eq("udf.flag", 32'(underflow), 32'd1);
`endif
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    check_eq("udf.rptr_kept", 32'(rd_data), 32'hA5);
    check_eq("udf.count", 32'(count), 32'd1);

    // Steady occupancy of four across pointer wrap.
    cyc(1'b1, 8'hB0, 1'b0, 1'b0);
    cyc(1'b1, 8'hB1, 1'b0, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0, 1'b0);
    check_state("wrap0");
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 8'(8'h10 + k), 1'b1, 1'b0);
      check_state("wrap");
      check_eq("wrap.count", 32'(count), 32'd4);
    end

    // Full with both requests: read wins, write dropped.
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'(8'hC0 + k), 1'b0, 1'b0);
    check_eq("full.flag", 32'(full), 32'd1);
    cyc(1'b1, 8'hEE, 1'b1, 1'b0);
    check_state("fullrw");
    check_eq("fullrw.count", 32'(count), 32'd7);
    for (int k = 0; k < 7; k++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check_state("drain2");
    end
    // Empty with both requests: write wins.
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    check_state("emptyrw");
    check_eq("emptyrw.count", 32'(count), 32'd1);
    check_eq("emptyrw.rd_data", 32'(rd_data), 32'h77);

    // Flush at count five with a concurrent write.
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
    check_eq("preflush.count", 32'(count), 32'd5);
    cyc(1'b1, 8'h99, 1'b0, 1'b1);
    check_state("flush");
    check_eq("flush.count", 32'(count), 32'd0);
    check_eq("flush.empty", 32'(empty), 32'd1);

    // Async reset pulse in the middle of a write burst.
    cyc(1'b1, 8'h41, 1'b0, 1'b0);
    cyc(1'b1, 8'h42, 1'b0, 1'b0);
    check_eq("prerst.count", 32'(count), 32'd2);
    w_inc   = 1'b1;
    wr_data = 8'h55;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst.count", 32'(count), 32'd0);
    check_eq("arst.empty", 32'(empty), 32'd1);
    check_eq("arst.aempty", 32'(aempty), 32'd1);
    check_eq("arst.rd_data", 32'(rd_data), 32'h00);
    w_inc = 1'b0;
    model_q.delete();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_state("postrst");
    cyc(1'b1, 8'h66, 1'b0, 1'b0);
    check_state("postrst_wr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
